sram_host_ctrl: RTL and testbench
=================================

Name: sram_host_ctrl

Overview:
Host-side command sequencer that sits directly upstream of sram_top and is the only block that drives its serial write and read pins.
- Accepts parallel read/write commands over a valid/ready handshake.
- For a write, serializes the word MSB-first onto serial_in/shift, then pulses w_en.
- For a read, pulses r_en, captures data_out on data_valid, and returns one response per command.

Parameters:
- ROWS, 16, number of SRAM rows; address width AW = $clog2(ROWS).
- COLS, 8, word width in bits.
- RD_TIMEOUT, 15, read-wait limit in cycles; used only when SRAM_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- arst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  target row.
- cmd_wdata  in  COLS  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  COLS  read data; '0 for writes.
- rsp_err  out  1  read timed out.
- sram_serial_in  out  1  to sram_top serial_in.
- sram_shift  out  1  to sram_top shift.
- sram_w_en  out  1  to sram_top w_en.
- sram_r_en  out  1  to sram_top r_en.
- sram_addr  out  AW  to sram_top addr.
- sram_data_valid  in  1  from sram_top data_valid.
- sram_data_out  in  COLS  from sram_top data_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Outputs are decoded from state and registers only. There is no combinational path from any cmd_* or sram_* input to any output.
- Reset: state IDLE, all registers 0. All outputs 0 except cmd_ready = 1.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, capture we/addr/wdata. A write goes to SHIFT; a read goes to READ.
- SHIFT: sram_shift = 1 for exactly COLS consecutive cycles. sram_serial_in = wdata_q[COLS-1-bitcnt]; bitcnt runs 0..COLS-1. After the last bit, go to WRITE.
- WRITE: sram_w_en = 1 for one cycle with sram_addr = addr_q. Then go to RESP with rdata = '0 and err = 0.
- READ: sram_r_en = 1 for one cycle with sram_addr = addr_q. Then go to WAIT_RD.
- WAIT_RD: on sram_data_valid, capture sram_data_out into rdata_q and go to RESP.
  - sram_data_valid is ignored in every other state.
  - sram_top read latency is >= 1 cycle after r_en.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready; return to IDLE on the handshake cycle.
- cmd_ready = 0 in every state except IDLE. A command is accepted on the cycle after a response handshake at the earliest.
- sram_addr holds addr_q from acceptance until return to IDLE. It is 0 in IDLE.
- Write latency, with acceptance edge = cycle 0:
  - sram_shift high in cycles 1..COLS;
  - sram_w_en in cycle COLS+1;
  - rsp_valid from cycle COLS+2.
- Read latency: sram_r_en in cycle 1; rsp_valid the cycle after sram_data_valid is seen.
- Reset mid-operation aborts the command.
  - No w_en/r_en is issued, no response is produced, and outputs return to reset values.
  - A partially shifted word in sram_top is don't-care; every write reshifts all COLS bits.

Optional Feature:
SRAM_CTRL_TIMEOUT_EN
- Defined: WAIT_RD runs a counter cleared on entry. If RD_TIMEOUT cycles pass with no sram_data_valid, go to RESP with rsp_err = 1 and rsp_rdata = '0. A data_valid arriving on the timeout cycle wins (err = 0).
- Undefined: WAIT_RD waits indefinitely and rsp_err is tied to 0.

Decomposition:
- Package sram_pkg holds:
  - ROWS/COLS defaults;
  - typedef addr_t (AW bits) and word_t (COLS bits);
  - enum ctrl_state_t {IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP}.
- Sub-module sram_ser: parallel-in/serial-out shifter with load, shift-enable, bit counter and done flag, MSB-first. The FSM stays in sram_host_ctrl.

Test Plan:
1. Reset, then write 8'hA5 to addr 3 -> sram_shift high cycles 1-8 with serial 1,0,1,0,0,1,0,1; sram_w_en one cycle at cycle 9 with addr 3; rsp_valid at cycle 10, err 0, rdata 0.
2. Write 8'hA5 to addr 3, then read addr 3 -> one r_en pulse with addr 3; rsp_rdata = 8'hA5, err 0.
3. Hold rsp_ready low 5 cycles during a read response -> rsp_valid/rsp_rdata stable; cmd_ready 0; a concurrent cmd_valid is not accepted until 1 cycle after the handshake.
4. Write all 16 rows with data = addr ^ 8'h5A, then read all back -> every rsp_rdata matches; exactly 16 w_en and 16 r_en pulses.
5. arst_n low in SHIFT cycle 4 -> no w_en pulse; outputs at reset values; cmd_ready 1 after release; the next write to addr 7 of 8'h3C reads back 8'h3C.
6. With SRAM_CTRL_TIMEOUT_EN and RD_TIMEOUT = 15, sram model withholds data_valid -> rsp_valid 16 cycles after r_en with rsp_err 1 and rdata 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM host-side controller.
package sram_pkg;

    localparam int unsigned DEFAULT_ROWS = 16;
    localparam int unsigned DEFAULT_COLS = 8;
    localparam int unsigned DEFAULT_AW   = $clog2(DEFAULT_ROWS);

    typedef logic [DEFAULT_AW-1:0]   addr_t;
    typedef logic [DEFAULT_COLS-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        WAIT_RD = 3'd4,
        RESP    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/sram_ser.sv
// MSB-first parallel-in/serial-out shifter with bit counter and last-bit flag.
module sram_ser #(
    parameter int unsigned COLS = 8
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            load,
    input  logic [COLS-1:0] load_data,
    input  logic            shift_en,
    output logic            serial,
    output logic            done
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [COLS-1:0] sreg;
    logic [CW-1:0]   bitcnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sreg   <= '0;
            bitcnt <= '0;
        end else if (load) begin
            sreg   <= load_data;
            bitcnt <= '0;
        end else if (shift_en) begin
            sreg   <= sreg << 1;
            bitcnt <= bitcnt + CW'(1);
        end
    end

    // Top bit of the shift register is wdata[COLS-1-bitcnt].
    assign serial = sreg[COLS-1];
    assign done   = (bitcnt == CW'(COLS - 1));

endmodule

// File: rtl/sram_host_ctrl.sv
// Host command sequencer driving sram_top's serial write and read pins.
// Optional read timeout enabled by defining SRAM_CTRL_TIMEOUT_EN.
module sram_host_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ROWS       = DEFAULT_ROWS,
    parameter int unsigned COLS       = DEFAULT_COLS,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [$clog2(ROWS)-1:0] cmd_addr,
    input  logic [COLS-1:0]         cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [COLS-1:0]         rsp_rdata,
    output logic                    rsp_err,
    output logic                    sram_serial_in,
    output logic                    sram_shift,
    output logic                    sram_w_en,
    output logic                    sram_r_en,
    output logic [$clog2(ROWS)-1:0] sram_addr,
    input  logic                    sram_data_valid,
    input  logic [COLS-1:0]         sram_data_out,
    output logic                    busy
);

    localparam int unsigned AW = $clog2(ROWS);

    ctrl_state_t     state;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] rdata_q;
    logic            ser_load;
    logic            ser_bit;
    logic            ser_done;

`ifdef SRAM_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
`endif

    assign ser_load = (state == IDLE) && cmd_valid && cmd_we;

    sram_ser #(
        .COLS(COLS)
    ) u_ser (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (ser_load),
        .load_data(cmd_wdata),
        .shift_en (state == SHIFT),
        .serial   (ser_bit),
        .done     (ser_done)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
`ifdef SRAM_CTRL_TIMEOUT_EN
            tcnt    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        rdata_q <= '0;
`ifdef SRAM_CTRL_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state   <= cmd_we ? SHIFT : READ;
                    end
                end
                SHIFT: begin
                    if (ser_done) state <= WRITE;
                end
                WRITE: state <= RESP;
                READ: begin
`ifdef SRAM_CTRL_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    // Data arriving on the timeout cycle takes priority.
                    if (sram_data_valid) begin
                        rdata_q <= sram_data_out;
                        state   <= RESP;
`ifdef SRAM_CTRL_TIMEOUT_EN
                    end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign sram_shift     = (state == SHIFT);
    assign sram_serial_in = (state == SHIFT) && ser_bit;
    assign sram_w_en      = (state == WRITE);
    assign sram_r_en      = (state == READ);
    assign sram_addr      = busy ? addr_q : '0;
    assign rsp_valid      = (state == RESP);
    assign rsp_rdata      = (state == RESP) ? rdata_q : '0;
`ifdef SRAM_CTRL_TIMEOUT_EN
    assign rsp_err        = (state == RESP) && err_q;
`else
    assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Randomized self-checking bench for sram_host_ctrl with a behavioural sram_top model.
module tb_sram_host_ctrl;

    localparam int ROWS       = 16;
    localparam int COLS       = 8;
    localparam int AW         = 4;
    localparam int RD_TIMEOUT = 15;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [COLS-1:0] cmd_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    logic            sram_serial_in;
    logic            sram_shift;
    logic            sram_w_en;
    logic            sram_r_en;
    logic [AW-1:0]   sram_addr;
    logic            sram_data_valid = 1'b0;
    logic [COLS-1:0] sram_data_out = '0;
    logic            busy;

    int checks = 0;
    int errors = 0;

    sram_host_ctrl #(
        .ROWS(ROWS),
        .COLS(COLS),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_serial_in(sram_serial_in), .sram_shift(sram_shift),
        .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
        .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // sram_top model: serial capture, w_en commit, r_en returns data after rd_lat cycles
    int              rd_lat = 2;
    bit              withhold = 1'b0;
    bit              noise = 1'b0;
    logic [COLS-1:0] sreg = '0;
    logic [COLS-1:0] sram_mem [ROWS];
    bit              pend = 1'b0;
    int              pcnt = 0;
    logic [AW-1:0]   raddr = '0;

    always @(posedge clk) begin
        sram_data_valid <= 1'b0;
        if (noise && !pend && ($urandom_range(0, 3) == 0)) begin
            sram_data_valid <= 1'b1;
            sram_data_out   <= COLS'($urandom);
        end
        if (sram_shift) sreg <= {sreg[COLS-2:0], sram_serial_in};
        if (sram_w_en) sram_mem[sram_addr] <= sreg;
        if (pend) begin
            if (pcnt == 0) begin
                sram_data_valid <= 1'b1;
                sram_data_out   <= sram_mem[raddr];
                pend            <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
        if (sram_r_en && !withhold) begin
            if (rd_lat <= 1) begin
                sram_data_valid <= 1'b1;
                sram_data_out   <= sram_mem[sram_addr];
            end else begin
                pend  <= 1'b1;
                pcnt  <= rd_lat - 2;
                raddr <= sram_addr;
            end
        end
    end

    int wen_cnt = 0;
    int ren_cnt = 0;
    always @(negedge clk) begin
        if (sram_w_en) wen_cnt++;
        if (sram_r_en) ren_cnt++;
    end

    // Reference contents: what the host has committed to each row
    logic [COLS-1:0] exp_mem [ROWS];

    task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                          input int hold, output logic [COLS-1:0] rd, output logic er,
                          output int lat, output int dvl, output bit tmo);
        int n;
        tmo = 1'b1; lat = 0; dvl = -100; rd = '0; er = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin tmo = 1'b0; break; end
            if (sram_data_valid) dvl = lat;
        end
        if (tmo) return;
        rd = rsp_rdata; er = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_err, sram_shift, sram_serial_in, sram_w_en, sram_r_en} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {cmd_ready, busy, rsp_valid, rsp_err, sram_shift, sram_serial_in, sram_w_en, sram_r_en});
        end
        checks++;
        if (sram_addr !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h rdata %h want 0 0", sram_addr, rsp_rdata);
        end
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_timing;
        logic [COLS-1:0] d;
        logic [AW-1:0]   a;
        logic [5:0]      got, want;
        d = 8'hA5; a = 4'd3;
        noise = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d;
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int k = 1; k <= COLS + 4; k++) begin
            @(negedge clk);
            want = {(k <= COLS), (k <= COLS) ? d[COLS-k] : 1'b0, (k == COLS + 1), 1'b0, (k >= COLS + 2), 1'b1};
            got  = {sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid, sram_addr == a};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL write_cycle%0d: {shift,ser,wen,ren,rv,addr_ok} got %b want %b", k, got, want);
            end
            if (k == COLS + 2) begin
                checks++;
                if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL write_rsp: rdata %h err %b want 00 0", rsp_rdata, rsp_err);
                end
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        noise = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic test_read_back;
        logic [COLS-1:0] rd; logic er; int lat, dvl; bit tmo; int r0;
        @(posedge clk); #1 r0 = ren_cnt;
        rd_lat = $urandom_range(1, 5);
        do_cmd(1'b0, 4'd3, '0, $urandom_range(0, 3), rd, er, lat, dvl, tmo);
        @(posedge clk); #1;
        checks++;
        if (tmo || rd !== exp_mem[3] || er !== 1'b0) begin
            errors++;
            $display("FAIL read_back: tmo %0d rdata %h err %b want %h 0", tmo, rd, er, exp_mem[3]);
        end
        checks++;
        if (lat != dvl + 1 || ren_cnt - r0 != 1) begin
            errors++;
            $display("FAIL read_latency: rsp cycle %0d dv cycle %0d r_en pulses %0d want dv+1 and 1",
                     lat, dvl, ren_cnt - r0);
        end
    endtask

    task automatic test_resp_hold;
        logic [COLS-1:0] held, nd;
        int n;
        bit seen;
        nd = COLS'($urandom);
        rd_lat = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'd3;
        @(posedge clk); #1;
        cmd_we = 1'b1; cmd_addr = 4'd5; cmd_wdata = nd;
        seen = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        held = rsp_rdata;
        checks++;
        if (!seen || held !== exp_mem[3]) begin
            errors++;
            $display("FAIL hold_first: seen %0d rdata %h want %h", seen, held, exp_mem[3]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable%0d: rv %b rdata %h ready %b want 1 %h 0",
                         i, rsp_valid, rsp_rdata, cmd_ready, held);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_hs: ready %b busy %b want 1 0", cmd_ready, busy);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sram_shift !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: busy %b shift %b want 1 1", busy, sram_shift);
        end
        seen = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL hold_write_rsp: seen %0d rdata %h want 1 00", seen, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        exp_mem[5] = nd;
    endtask

    task automatic test_all_rows;
        logic [COLS-1:0] rd; logic er; int lat, dvl; bit tmo; int w0, r0, bad;
        @(posedge clk); #1 w0 = wen_cnt; r0 = ren_cnt;
        noise = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            do_cmd(1'b1, AW'(i), COLS'(i) ^ 8'h5A, $urandom_range(0, 2), rd, er, lat, dvl, tmo);
            exp_mem[i] = COLS'(i) ^ 8'h5A;
            checks++;
            if (tmo || rd !== '0 || lat != COLS + 2) begin
                errors++;
                $display("FAIL rows_write%0d: tmo %0d rdata %h lat %0d want 0 00 %0d", i, tmo, rd, lat, COLS + 2);
            end
        end
        noise = 1'b0;
        bad = 0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            rd_lat = $urandom_range(1, 6);
            do_cmd(1'b0, AW'(i), '0, $urandom_range(0, 2), rd, er, lat, dvl, tmo);
            checks++;
            if (tmo || rd !== exp_mem[i] || er !== 1'b0 || lat != dvl + 1) begin
                errors++;
                $display("FAIL rows_read%0d: tmo %0d rdata %h err %b lat %0d dv %0d want %h 0 dv+1",
                         i, tmo, rd, er, lat, dvl, exp_mem[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (wen_cnt - w0 != ROWS || ren_cnt - r0 != ROWS) begin
            errors++;
            $display("FAIL rows_pulses: w_en %0d r_en %0d want %0d %0d", wen_cnt - w0, ren_cnt - r0, ROWS, ROWS);
        end
    endtask

    task automatic test_reset_abort;
        logic [COLS-1:0] rd; logic er; int lat, dvl; bit tmo; int w0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'd7; cmd_wdata = 8'hC3;
        @(posedge clk); #1 cmd_valid = 1'b0;
        w0 = wen_cnt;
        repeat (4) @(negedge clk);
        checks++;
        if (sram_shift !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_shift: shift %b want 1", sram_shift);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid} !== 7'b1000000 || sram_addr !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %b addr %h want 1000000 0",
                     {cmd_ready, busy, sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid}, sram_addr);
        end
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (wen_cnt != w0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: w_en pulses %0d ready %b rv %b want 0 1 0", wen_cnt - w0, cmd_ready, rsp_valid);
        end
        do_cmd(1'b1, 4'd7, 8'h3C, 0, rd, er, lat, dvl, tmo);
        exp_mem[7] = 8'h3C;
        rd_lat = 2;
        do_cmd(1'b0, 4'd7, '0, 1, rd, er, lat, dvl, tmo);
        checks++;
        if (tmo || rd !== 8'h3C) begin
            errors++;
            $display("FAIL abort_readback: tmo %0d rdata %h want 3c", tmo, rd);
        end
    endtask

`ifdef SRAM_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        logic [COLS-1:0] rd; logic er; int lat, dvl; bit tmo;
        withhold = 1'b1;
        do_cmd(1'b0, 4'd5, '0, 0, rd, er, lat, dvl, tmo);
        withhold = 1'b0;
        checks++;
        if (tmo || lat != RD_TIMEOUT + 2 || er !== 1'b1 || rd !== '0) begin
            errors++;
            $display("FAIL timeout: tmo %0d lat %0d err %b rdata %h want 0 %0d 1 00", tmo, lat, er, rd, RD_TIMEOUT + 2);
        end
        rd_lat = RD_TIMEOUT;
        do_cmd(1'b0, 4'd3, '0, 0, rd, er, lat, dvl, tmo);
        checks++;
        if (tmo || lat != RD_TIMEOUT + 2 || er !== 1'b0 || rd !== exp_mem[3]) begin
            errors++;
            $display("FAIL timeout_edge: tmo %0d lat %0d err %b rdata %h want 0 %0d 0 %h",
                     tmo, lat, er, rd, RD_TIMEOUT + 2, exp_mem[3]);
        end
    endtask
`else
    task automatic test_timeout;
        logic [COLS-1:0] rd; logic er; int lat, dvl; bit tmo;
        withhold = 1'b1;
        do_cmd(1'b0, 4'd5, '0, 0, rd, er, lat, dvl, tmo);
        withhold = 1'b0;
        checks++;
        if (tmo !== 1'b1 || busy !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_forever: tmo %0d busy %b err %b want 1 1 0", tmo, busy, rsp_err);
        end
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_reset: ready %b busy %b want 1 0", cmd_ready, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_timing();
        test_read_back();
        test_resp_hold();
        test_all_rows();
        test_reset_abort();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
